// File: rtl/audio_flt_cfg_ctrl.sv
// IIR coefficient sequencer: byte-wise shadow writes, atomic commit wrapped in mute/clear/settle.
// Latency: busy/mute one cycle after commit; swap one cycle after the MUTE_SAMPLES-th sample_ce.
// Backpressure: none; one commit arriving mid-sequence is held pending, later ones are absorbed.
module audio_flt_cfg_ctrl #(
    parameter logic [31:0] DEF_FLT_RATE   = 32'd7056000,
    parameter logic [39:0] DEF_CX         = 40'd4258969,
    parameter logic [7:0]  DEF_CX0        = 8'd3,
    parameter logic [7:0]  DEF_CX1        = 8'd3,
    parameter logic [7:0]  DEF_CX2        = 8'd1,
    parameter logic [23:0] DEF_CY0        = -24'd6216759,
    parameter logic [23:0] DEF_CY1        = 24'd6143386,
    parameter logic [23:0] DEF_CY2        = -24'd2023767,
    parameter int          MUTE_SAMPLES   = 4,
    parameter int          SETTLE_SAMPLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_ce,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        commit,
    output logic        busy,
    output logic [31:0] flt_rate,
    output logic [39:0] cx,
    output logic [7:0]  cx0,
    output logic [7:0]  cx1,
    output logic [7:0]  cx2,
    output logic [23:0] cy0,
    output logic [23:0] cy1,
    output logic [23:0] cy2,
    output logic        flt_clr,
    output logic        audio_mute
);

    localparam int MAX_SAMPLES = (MUTE_SAMPLES > SETTLE_SAMPLES) ? MUTE_SAMPLES : SETTLE_SAMPLES;
    localparam int CW          = $clog2(MAX_SAMPLES + 1);
    localparam logic [CW-1:0] MUTE_LAST   = CW'(MUTE_SAMPLES);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_SAMPLES);

    // Byte image of the whole coefficient set, byte 0 in the LSBs.
    localparam logic [167:0] DEF_SET = {DEF_CY2, DEF_CY1, DEF_CY0, DEF_CX2, DEF_CX1,
                                        DEF_CX0, DEF_CX, DEF_FLT_RATE};

    typedef enum logic [1:0] {IDLE, FADE, APPLY, SETTLE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
    logic            pending, pending_nxt;
    logic [167:0]    shadow, live;

    assign cnt_inc = cnt + CW'(1);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pending_nxt = pending;
        if (commit && state != IDLE)
            pending_nxt = 1'b1;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (commit || pending) begin
                    state_nxt   = FADE;
                    pending_nxt = 1'b0;
                end
            end
            FADE: begin
                if (sample_ce) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == MUTE_LAST)
                        state_nxt = APPLY;
                end
            end
            APPLY: begin
                cnt_nxt   = '0;
                state_nxt = SETTLE;
            end
            SETTLE: begin
                if (sample_ce) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == SETTLE_LAST)
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are flopped from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            pending    <= 1'b0;
            busy       <= 1'b0;
            audio_mute <= 1'b0;
            flt_clr    <= 1'b0;
            shadow     <= DEF_SET;
            live       <= DEF_SET;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pending    <= pending_nxt;
            busy       <= (state_nxt != IDLE);
            audio_mute <= (state_nxt != IDLE);
            flt_clr    <= (state_nxt == APPLY);
            if (wr_en && wr_addr < 5'd21)
                shadow[{wr_addr, 3'b000} +: 8] <= wr_data;
            // Old shadow is sampled here, so a write in the APPLY cycle misses this swap.
            if (state == APPLY)
                live <= shadow;
        end
    end

    assign flt_rate = live[31:0];
    assign cx       = live[71:32];
    assign cx0      = live[79:72];
    assign cx1      = live[87:80];
    assign cx2      = live[95:88];
    assign cy0      = live[119:96];
    assign cy1      = live[143:120];
    assign cy2      = live[167:144];

endmodule

// File: tb/tb_audio_flt_cfg_ctrl.sv
// Directed bench for audio_flt_cfg_ctrl: reset values, commit sequencing, pending commits,
// APPLY-cycle writes, reset abort and ignored addresses.
module tb_audio_flt_cfg_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_ce;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        commit;
    logic        busy;
    logic [31:0] flt_rate;
    logic [39:0] cx;
    logic [7:0]  cx0, cx1, cx2;
    logic [23:0] cy0, cy1, cy2;
    logic        flt_clr;
    logic        audio_mute;

    int vectors     = 0;
    int miscompares = 0;

    audio_flt_cfg_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .sample_ce  (sample_ce),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit     (commit),
        .busy       (busy),
        .flt_rate   (flt_rate),
        .cx         (cx),
        .cx0        (cx0),
        .cx1        (cx1),
        .cx2        (cx2),
        .cy0        (cy0),
        .cy1        (cy1),
        .cy2        (cy2),
        .flt_clr    (flt_clr),
        .audio_mute (audio_mute)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic ce_pulse(input int gap);
        repeat (gap) tick();
        sample_ce = 1'b1;
        tick();
        sample_ce = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sample_ce = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset values
        chk("rst_cx",       cx,         64'd4258969);
        chk("rst_cy0",      cy0,        64'hA123C9);
        chk("rst_flt_rate", flt_rate,   64'd7056000);
        chk("rst_busy",     busy,       64'd0);
        chk("rst_mute",     audio_mute, 64'd0);
        chk("rst_clr",      flt_clr,    64'd0);

        // New flt_rate, sample_ce every 512 cycles
        wr(5'd0, 8'h00); wr(5'd1, 8'hB8); wr(5'd2, 8'h0D); wr(5'd3, 8'h00);
        chk("t2_rate_pre", flt_rate, 64'd7056000);
        do_commit();
        chk("t2_busy_on", busy,       64'd1);
        chk("t2_mute_on", audio_mute, 64'd1);
        repeat (3) ce_pulse(511);
        chk("t2_clr_3rd",  flt_clr,  64'd0);
        chk("t2_rate_3rd", flt_rate, 64'd7056000);
        ce_pulse(511);
        chk("t2_clr_apply",  flt_clr,  64'd1);
        chk("t2_rate_apply", flt_rate, 64'd7056000);
        tick();
        chk("t2_clr_off",   flt_clr,  64'd0);
        chk("t2_rate_live", flt_rate, 64'h000DB800);
        repeat (15) ce_pulse(511);
        chk("t2_mute_15", audio_mute, 64'd1);
        ce_pulse(511);
        chk("t2_mute_off", audio_mute, 64'd0);
        chk("t2_busy_off", busy,       64'd0);

        // Commits during FADE and SETTLE collapse into one extra sequence
        do_commit();
        ce_pulse(3);
        do_commit();
        do_commit();
        repeat (3) ce_pulse(3);
        tick();
        do_commit();
        wr(5'd11, 8'h22);
        repeat (16) ce_pulse(3);
        chk("t3_gap_busy", busy, 64'd0);
        tick();
        chk("t3_restart_busy", busy, 64'd1);
        chk("t3_cx2_pre",      cx2,  64'd1);
        repeat (4) ce_pulse(3);
        tick();
        chk("t3_cx2_live", cx2, 64'h22);
        repeat (16) ce_pulse(3);
        chk("t3_end_busy", busy, 64'd0);
        tick(); tick();
        chk("t3_no_third", busy, 64'd0);

        // Write on the APPLY cycle waits for the next commit
        do_commit();
        repeat (4) ce_pulse(3);
        chk("t4_in_apply", flt_clr, 64'd1);
        wr(5'd9, 8'h07);
        chk("t4_cx0_old", cx0, 64'd3);
        repeat (16) ce_pulse(3);
        do_commit();
        repeat (4) ce_pulse(3);
        tick();
        chk("t4_cx0_new", cx0, 64'h07);
        repeat (16) ce_pulse(3);

        // Reset during SETTLE aborts and restores defaults
        wr(5'd9, 8'h09);
        do_commit();
        repeat (4) ce_pulse(3);
        tick();
        chk("t5_cx0_live", cx0, 64'h09);
        repeat (5) ce_pulse(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_busy",  busy,       64'd0);
        chk("t5_mute",  audio_mute, 64'd0);
        chk("t5_clr",   flt_clr,    64'd0);
        chk("t5_cx0",   cx0,        64'd3);
        chk("t5_rate",  flt_rate,   64'd7056000);
        chk("t5_cx2",   cx2,        64'd1);

        // Out-of-map writes; coincident sample_ce on the commit cycle is ignored
        wr(5'd21, 8'hFF);
        wr(5'd31, 8'hFF);
        sample_ce = 1'b1;
        do_commit();
        sample_ce = 1'b0;
        repeat (3) ce_pulse(3);
        chk("t6_not_yet", flt_clr, 64'd0);
        ce_pulse(3);
        chk("t6_apply", flt_clr, 64'd1);
        tick();
        chk("t6_rate", flt_rate, 64'd7056000);
        chk("t6_cx",   cx,       64'd4258969);
        chk("t6_cx0",  cx0,      64'd3);
        chk("t6_cx1",  cx1,      64'd3);
        chk("t6_cx2",  cx2,      64'd1);
        chk("t6_cy0",  cy0,      64'hA123C9);
        chk("t6_cy1",  cy1,      64'd6143386);
        chk("t6_cy2",  cy2,      64'hE11EA9);
        repeat (16) ce_pulse(3);
        chk("t6_busy_off", busy, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
